// File: rtl/laundromat_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : laundromat_pkg                                     |
// | Description : Shared types and default sizes for the laundromat  |
// |               scheduler (slot state encoding, default machine    |
// |               count, request queue depth, served counter width). |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
package laundromat_pkg;

  localparam int DEF_N_MACH = 4;
  localparam int DEF_QDEPTH = 8;
  localparam int DEF_CNT_W  = 16;

  // Per-machine slot state held by the scheduler.
  typedef enum logic [0:0] {
    SLOT_IDLE = 1'b0,
    SLOT_RUN  = 1'b1
  } slot_state_t;

endpackage : laundromat_pkg
`default_nettype wire

// File: rtl/wash_req_fifo.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : wash_req_fifo                                      |
// | Description : 1-bit wide request queue holding the double_wash   |
// |               flag of each pending customer request.             |
// | Ports       : CLK, rst_n (async active-low)                      |
// |               push/push_data -> enqueue, push_accept reports it  |
// |               pop            -> dequeue head (ignored if empty)  |
// |               head_data, count, full, empty -> status            |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
module wash_req_fifo #(
  parameter int QDEPTH = 8
) (
  input  logic                         CLK,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic                         push_data,
  input  logic                         pop,
  output logic                         push_accept,
  output logic                         head_data,
  output logic [$clog2(QDEPTH+1)-1:0]  count,
  output logic                         full,
  output logic                         empty
);

  localparam int PTR_W = $clog2(QDEPTH);
  localparam int CW    = $clog2(QDEPTH+1);

  logic [QDEPTH-1:0] mem_q,    mem_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q,  count_d;
  logic              pop_ok;

  assign full        = (count_q == CW'(QDEPTH));
  assign empty       = (count_q == '0);
  assign pop_ok      = pop && !empty;
  // A pop in the same cycle frees the slot the push needs, even when full.
  assign push_accept = push && (!full || pop_ok);
  assign head_data   = mem_q[rd_ptr_q];
  assign count       = count_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_accept) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push_accept, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule : wash_req_fifo
`default_nettype wire

// File: rtl/laundromat_scheduler.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : laundromat_scheduler                               |
// | Description : Queues coin requests and dispatches them round-    |
// |               robin to idle washing machines; fans out pause.    |
// | Ports       : CLK, rst_n (async active-low)                      |
// |               coin_in, double_wash, pause_all  <- front end      |
// |               mach_wash_done                   <- machines       |
// |               mach_coin, mach_double_wash,                       |
// |               mach_timer_pause                 -> machines       |
// |               busy_mask, queue_count, queue_full, coin_reject,   |
// |               served_count                     -> status         |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
module laundromat_scheduler
  import laundromat_pkg::*;
#(
  parameter int N_MACH = DEF_N_MACH,
  parameter int QDEPTH = DEF_QDEPTH,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic                         CLK,
  input  logic                         rst_n,
  input  logic                         coin_in,
  input  logic                         double_wash,
  input  logic                         pause_all,
  input  logic [N_MACH-1:0]            mach_wash_done,
  output logic [N_MACH-1:0]            mach_coin,
  output logic [N_MACH-1:0]            mach_double_wash,
  output logic [N_MACH-1:0]            mach_timer_pause,
  output logic [N_MACH-1:0]            busy_mask,
  output logic [$clog2(QDEPTH+1)-1:0]  queue_count,
  output logic                         queue_full,
  output logic                         coin_reject,
  output logic [CNT_W-1:0]             served_count
);

  localparam int IDX_W = $clog2(N_MACH);

  slot_state_t       slot_q [N_MACH];
  slot_state_t       slot_d [N_MACH];
  logic [N_MACH-1:0] done_prev_q;
  logic [N_MACH-1:0] done_rise;
  logic [IDX_W-1:0]  rr_ptr_q,  rr_ptr_d;
  logic [N_MACH-1:0] coin_q,    coin_d;
  logic [N_MACH-1:0] dw_q,      dw_d;
  logic [N_MACH-1:0] pause_q;
  logic              reject_q,  reject_d;
  logic [CNT_W-1:0]  served_q,  served_d;

  logic              fifo_head;
  logic              fifo_empty;
  logic              push_accept;
  logic              dispatch;
  logic              pick_valid;
  logic [IDX_W-1:0]  pick_idx;
  int                cand;
  int                nxt;

  wash_req_fifo #(.QDEPTH(QDEPTH)) u_fifo (
    .CLK         (CLK),
    .rst_n       (rst_n),
    .push        (coin_in),
    .push_data   (double_wash),
    .pop         (dispatch),
    .push_accept (push_accept),
    .head_data   (fifo_head),
    .count       (queue_count),
    .full        (queue_full),
    .empty       (fifo_empty)
  );

  // A slot is freed only by a fresh 0->1 of its done level.
  assign done_rise = mach_wash_done & ~done_prev_q;

  // Round-robin pick: scan offsets from high to low so the lowest
  // offset from rr_ptr that is idle is the one left in pick_idx.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    for (int k = N_MACH - 1; k >= 0; k--) begin
      cand = int'(rr_ptr_q) + k;
      if (cand >= N_MACH) cand = cand - N_MACH;
      if (slot_q[IDX_W'(cand)] == SLOT_IDLE) begin
        pick_valid = 1'b1;
        pick_idx   = IDX_W'(cand);
      end
    end
  end

  assign dispatch = pick_valid && !fifo_empty;

  // Slot FSM state register.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_MACH; i++) slot_q[i] <= SLOT_IDLE;
    end else begin
      for (int i = 0; i < N_MACH; i++) slot_q[i] <= slot_d[i];
    end
  end

  // Slot FSM next state.
  always_comb begin
    for (int i = 0; i < N_MACH; i++) begin
      slot_d[i] = slot_q[i];
      case (slot_q[i])
        SLOT_IDLE: if (dispatch && pick_idx == IDX_W'(i)) slot_d[i] = SLOT_RUN;
        SLOT_RUN:  if (done_rise[i])                      slot_d[i] = SLOT_IDLE;
        default:   slot_d[i] = SLOT_IDLE;
      endcase
    end
  end

  // Slot FSM outputs.
  always_comb begin
    busy_mask = '0;
    for (int i = 0; i < N_MACH; i++) busy_mask[i] = (slot_q[i] == SLOT_RUN);
  end

  // Dispatch datapath next values.
  always_comb begin
    coin_d   = '0;
    dw_d     = dw_q;
    rr_ptr_d = rr_ptr_q;
    served_d = served_q;
    reject_d = coin_in && !push_accept;
    nxt      = 0;
    for (int i = 0; i < N_MACH; i++) begin
      if (slot_q[i] == SLOT_RUN && done_rise[i]) dw_d[i] = 1'b0;
    end
    if (dispatch) begin
      coin_d[pick_idx] = 1'b1;
      dw_d[pick_idx]   = fifo_head;
      served_d         = served_q + CNT_W'(1);
      nxt              = int'(pick_idx) + 1;
      if (nxt == N_MACH) nxt = 0;
      rr_ptr_d = IDX_W'(nxt);
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      done_prev_q <= '0;
      rr_ptr_q    <= '0;
      coin_q      <= '0;
      dw_q        <= '0;
      pause_q     <= '0;
      reject_q    <= 1'b0;
      served_q    <= '0;
    end else begin
      done_prev_q <= mach_wash_done;
      rr_ptr_q    <= rr_ptr_d;
      coin_q      <= coin_d;
      dw_q        <= dw_d;
      pause_q     <= {N_MACH{pause_all}};
      reject_q    <= reject_d;
      served_q    <= served_d;
    end
  end

  assign mach_coin        = coin_q;
  assign mach_double_wash = dw_q;
  assign mach_timer_pause = pause_q;
  assign coin_reject      = reject_q;
  assign served_count     = served_q;

endmodule : laundromat_scheduler
`default_nettype wire

// File: doc/laundromat_scheduler.md
Name: laundromat_scheduler

Overview:
- Front-end scheduler for a bank of N_MACH washing-machine instances sharing one coin acceptor.
- Customer coin/double-wash requests are queued in a FIFO and dispatched round-robin to idle machines.
- Each job starts with a one-cycle coin pulse to the chosen machine. The machine is freed when its wash_done rises.
- Sits between the coin/debounce logic and the per-machine FSM+timer instances; also fans out a global pause.

Parameters:
N_MACH, 4, number of machines scheduled (2..8)
QDEPTH, 8, request FIFO depth (power of 2)
CNT_W, 16, width of served-job counter

Ports:
CLK  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
coin_in  input  1  one request per cycle high (pulse from debouncer)
double_wash  input  1  request type, sampled with coin_in
pause_all  input  1  global pause request
mach_wash_done  input  N_MACH  per-machine wash_done level
mach_coin  output  N_MACH  one-cycle start pulse to machine i
mach_double_wash  output  N_MACH  job type, held for the whole job
mach_timer_pause  output  N_MACH  registered copy of pause_all to every machine
busy_mask  output  N_MACH  bit i = machine i in RUN
queue_count  output  $clog2(QDEPTH+1)  entries waiting
queue_full  output  1  queue_count==QDEPTH
coin_reject  output  1  one-cycle pulse: coin dropped because queue full
served_count  output  CNT_W  jobs dispatched since reset, wraps

Behaviour:
- Reset (async, rst_n=0): all outputs 0, FIFO empty, all slots IDLE, RR pointer=0, done-edge registers=0.
- Enqueue: coin_in=1 and (not full, or a dequeue occurs in the same cycle) -> {double_wash} written. Otherwise coin_reject=1 next cycle and the request is lost.
- Simultaneous enqueue+dequeue at full: both happen, count unchanged, no reject.
- Dispatch: at most one per cycle. Condition: FIFO non-empty and at least one slot IDLE (registered state).
  - Chosen machine = first IDLE index at or after rr_ptr, modulo N_MACH; rr_ptr then = chosen+1 mod N_MACH.
- Dispatch outputs, registered, in the cycle after the decision:
  - mach_coin[i]=1 for exactly one cycle.
  - mach_double_wash[i]=head bit, held until slot returns to IDLE.
  - slot i -> RUN; served_count+1.
- Latency: coin_in high at cycle t, queue empty, a machine idle -> entry visible at t+1, mach_coin high at t+2.
- Per-slot FSM: IDLE -> RUN on dispatch; RUN -> IDLE on rising edge of mach_wash_done[i] (prev-cycle register, 0->1).
  - Rising edge while IDLE: ignored.
  - Level-high done at dispatch does not free the slot; only a new 0->1 does.
  - Freed slot can be re-dispatched the cycle after it returns to IDLE. mach_double_wash[i] clears to 0 on return to IDLE.
- mach_timer_pause = {N_MACH{pause_all}}, one-cycle registered. Pause does not block dispatch.
- busy_mask mirrors slot state directly (no extra delay).
- served_count wraps 2^CNT_W-1 -> 0.
- Reset mid-job: machines lose coin/double_wash drive immediately; queued requests are discarded.

Decomposition:
- Package laundromat_pkg: slot_state_t enum {SLOT_IDLE, SLOT_RUN}; localparams for default N_MACH, QDEPTH.
- Sub-module wash_req_fifo:
  - 1-bit wide, QDEPTH deep, count output, same-cycle push/pop at full allowed.
  - Same CLK/rst_n.
- Round-robin pick and slot FSMs stay in the top.

Test Plan:
- Reset, single coin (double_wash=1) at t=10, all done=0 -> mach_coin=4'b0001 at t=12, mach_double_wash[0]=1, busy_mask=0001, served_count=1.
- 5 coins on consecutive cycles, no done -> machines 0,1,2,3 each get one pulse on consecutive cycles. queue_count settles at 1, busy_mask=1111.
- Continue to 8 queued with all busy, then 9th coin -> coin_reject pulse, queue_count stays 8. Coin in same cycle as a dispatch at full -> no reject.
- Raise mach_wash_done[2] 0->1 with 3 queued -> slot 2 IDLE, next dispatch goes to machine 2. rr_ptr=3 so next free is checked from 3. Holding done high does not re-free it.
- pause_all=1 for 5 cycles -> mach_timer_pause=1111 for those 5 cycles delayed by 1. Dispatches continue unaffected.
- rst_n low mid-operation with 4 busy and 3 queued -> all outputs 0 asynchronously. After release, queue_count=0, served_count=0, first coin goes to machine 0.
